mdu_pipe: RTL and testbench

Parametrised multiply/divide unit holding the HI/LO architectural registers. It sits in the execute stage beside the ALU and gives the hazard unit a `Start`/`Busy` handshake. It generalises the fixed-latency MDU: operand width and multiply/divide latencies are parameters, and it adds a `Flush` input to abort an in-flight operation, a `Done` pulse, and defined divide-by-zero and overflow results.

---
 rtl/mdu_pkg.sv | 40 ++++
 rtl/mdu_arith.sv | 70 +++++++
 rtl/mdu_pipe.sv | 120 ++++++++++++
 tb/tb_mdu_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state type and op classification for the multiply/divide unit.
// Defining MDU_MADD_EN makes MADD/MADDU/MSUB/MSUBU multiply-class operations.
package mdu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] MULT  = 4'd0;
  localparam logic [OP_W-1:0] MULTU = 4'd1;
  localparam logic [OP_W-1:0] DIV   = 4'd2;
  localparam logic [OP_W-1:0] DIVU  = 4'd3;
  localparam logic [OP_W-1:0] MTHI  = 4'd4;
  localparam logic [OP_W-1:0] MTLO  = 4'd5;
  localparam logic [OP_W-1:0] MADD  = 4'd6;
  localparam logic [OP_W-1:0] MADDU = 4'd7;
  localparam logic [OP_W-1:0] MSUB  = 4'd8;
  localparam logic [OP_W-1:0] MSUBU = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_mult(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MULT, MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the next {HI,LO} for an op.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) exist only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   srca,
  input  logic [WIDTH-1:0]   srcb,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] res
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic [W2-1:0]           a_sx, b_sx, a_zx, b_zx;
  logic [W2-1:0]           prod_s, prod_u;
  logic [WIDTH-1:0]        b_safe;
  logic signed [WIDTH-1:0] sq, sr;
  logic [WIDTH-1:0]        uq, ur;
  logic                    div_zero, div_ovf;

  // Extended operands make the 2W-bit truncated product exact for both signednesses
  always_comb begin
    a_sx   = {{WIDTH{srca[WIDTH-1]}}, srca};
    b_sx   = {{WIDTH{srcb[WIDTH-1]}}, srcb};
    a_zx   = {{WIDTH{1'b0}}, srca};
    b_zx   = {{WIDTH{1'b0}}, srcb};
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;
  end

  // Divisor is forced nonzero so the quotient logic never sees x/0; the special cases override it
  always_comb begin
    div_zero = (srcb == '0);
    div_ovf  = (srca == {1'b1, {(WIDTH-1){1'b0}}}) && (srcb == {WIDTH{1'b1}});
    b_safe   = div_zero ? WIDTH'(1) : srcb;
    sq       = $signed(srca) / $signed(b_safe);
    sr       = $signed(srca) % $signed(b_safe);
    uq       = srca / b_safe;
    ur       = srca % b_safe;
  end

  always_comb begin
    res = {hi, lo};
    case (op)
      MULT:  res = prod_s;
      MULTU: res = prod_u;
      DIV: begin
        if (div_zero)     res = {srca, {WIDTH{1'b1}}};
        else if (div_ovf) res = {{WIDTH{1'b0}}, srca};
        else              res = {sr, sq};
      end
      DIVU: begin
        if (div_zero) res = {srca, {WIDTH{1'b1}}};
        else          res = {ur, uq};
      end
`ifdef MDU_MADD_EN
      MADD:  res = {hi, lo} + prod_s;
      MADDU: res = {hi, lo} + prod_u;
      MSUB:  res = {hi, lo} - prod_s;
      MSUBU: res = {hi, lo} - prod_u;
`endif
      default: res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu_pipe.sv
// Multi-cycle multiply/divide unit owning HI/LO, with Start/Busy handshake, Flush and Done.
// MDU_MADD_EN enables the accumulate ops at multiply latency.
module mdu_pipe
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [OP_W-1:0]  MDOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [2*WIDTH-1:0] pend, arith_res;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, done_d;
  logic               go, md_op, last;
  logic               launch, commit, hi_we, lo_we;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op   (MDOp),
    .srca (SrcA),
    .srcb (SrcB),
    .hi   (hi_q),
    .lo   (lo_q),
    .res  (arith_res)
  );

  assign go    = Start && !Flush;
  assign md_op = is_mult(MDOp) || is_div(MDOp);
  assign last  = (cnt == CNT_W'(1));

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_d;
  end

  // Flush wins over a same-cycle completion, so an aborted op never commits
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (go && md_op) state_d = RUN;
      RUN:     if (Flush || last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    launch = 1'b0;
    commit = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    done_d = 1'b0;
    cnt_d  = cnt;
    case (state)
      IDLE: begin
        if (go && md_op) begin
          launch = 1'b1;
          cnt_d  = is_div(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (go) begin
          hi_we = (MDOp == MTHI);
          lo_we = (MDOp == MTLO);
        end
      end
      RUN: begin
        if (Flush) begin
          cnt_d = '0;
        end else if (last) begin
          commit = 1'b1;
          done_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt    <= '0;
      pend   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      done_q <= done_d;
      if (launch) pend <= arith_res;
      if (commit) begin
        hi_q <= pend[2*WIDTH-1:WIDTH];
        lo_q <= pend[WIDTH-1:0];
      end else begin
        if (hi_we) hi_q <= SrcA;
        if (lo_we) lo_q <= SrcA;
      end
    end
  end

  assign Busy = (state == RUN);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_pipe.sv
// Scoreboard bench for mdu_pipe: randomized ops against an arithmetic reference model.
module tb_mdu_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic         Clk = 1'b0;
  logic         Reset, Start, Flush;
  logic [3:0]   MDOp;
  logic [W-1:0] SrcA, SrcB;
  logic         Busy, Done;
  logic [W-1:0] HI, LO;

  int n_total = 0;
  int n_pass  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  mdu_pipe #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .MDOp  (MDOp),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .Flush (Flush),
    .Busy  (Busy),
    .Done  (Done),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk)
    if (Reset === 1'b0) assert (!(Start && Busy)) else $error("start issued while busy");

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Reference: full-precision integer arithmetic, wrapped to 64 bits
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint sa, sb, q, rm;
    logic [63:0] ps, pu, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = 64'(sa * sb);
    pu = {32'd0, a} * {32'd0, b};
    r  = {hi, lo};
    case (op)
      4'd0: r = ps;
      4'd1: r = pu;
      4'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          q  = sa / sb;
          rm = sa - q * sb;
          r  = {32'(rm), 32'(q)};
        end
      end
      4'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
`ifdef MDU_MADD_EN
      4'd6: r = {hi, lo} + ps;
      4'd7: r = {hi, lo} + pu;
      4'd8: r = {hi, lo} - ps;
      4'd9: r = {hi, lo} - pu;
`endif
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  function automatic int lat(input logic [3:0] op);
    case (op)
      4'd0, 4'd1: return MC;
      4'd2, 4'd3: return DC;
`ifdef MDU_MADD_EN
      4'd6, 4'd7, 4'd8, 4'd9: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int n, l;
    e = model(op, a, b, m_hi, m_lo);
    l = lat(op);
    Start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
    if (l > 0) exp_q.push_back(e);
    tick;
    Start = 1'b0;
    if (l > 0) begin
      n = 0;
      while (Busy === 1'b1 && n < 200) begin
        n++;
        tick;
      end
      check("busy_cycles", 64'(n), 64'(l));
      check("done_pulse", 64'(Done), 64'd1);
      m_hi = e[63:32];
      m_lo = e[31:0];
      tick;
      check("done_one_cycle", 64'(Done), 64'd0);
    end else begin
      if (op == 4'd4) m_hi = a;
      if (op == 4'd5) m_lo = a;
      check("idle_op_busy", 64'(Busy), 64'd0);
      check("idle_op_hilo", {HI, LO}, {m_hi, m_lo});
    end
  endtask

  function automatic logic [31:0] pick;
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every Done pulse pops one expected {HI,LO}
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_done", 64'(Done), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("done_hilo", {HI, LO}, e);
        end
      end
    end
  end

  initial begin
    logic [3:0] op;
    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; MDOp = 4'd0; SrcA = '0; SrcB = '0;
    m_hi = '0; m_lo = '0;
    tick;
    tick;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    Reset = 1'b0;
    tick;

    issue(4'd0, 32'hFFFF_FFFF, 32'd2);
    check("mult_neg1x2", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    check("multu_max_x2", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
    issue(4'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", {HI, LO}, 64'h0000_0000_8000_0000);
    issue(4'd3, 32'd5, 32'd0);
    check("divu_by_zero", {HI, LO}, 64'h0000_0005_FFFF_FFFF);
    issue(4'd2, 32'd9, 32'd0);
    check("div_by_zero", {HI, LO}, 64'h0000_0009_FFFF_FFFF);

    // Flush during the third busy cycle
    Start = 1'b1; MDOp = 4'd0; SrcA = 32'd7; SrcB = 32'd9;
    tick;
    Start = 1'b0;
    tick;
    tick;
    Flush = 1'b1;
    tick;
    Flush = 1'b0;
    check("flush_busy", 64'(Busy), 64'd0);
    check("flush_hilo", {HI, LO}, {m_hi, m_lo});
    repeat (8) tick;
    check("flush_hilo_later", {HI, LO}, {m_hi, m_lo});

    // Start together with Flush is dropped
    Start = 1'b1; Flush = 1'b1; MDOp = 4'd2; SrcA = 32'd100; SrcB = 32'd3;
    tick;
    Start = 1'b0; Flush = 1'b0;
    check("start_flush_busy", 64'(Busy), 64'd0);
    repeat (12) tick;
    check("start_flush_hilo", {HI, LO}, {m_hi, m_lo});

    issue(4'd4, 32'h0000_1234, 32'd0);
    check("mthi", 64'(HI), 64'h1234);

    issue(4'd4, 32'd0, 32'd0);
    issue(4'd5, 32'd1, 32'd0);
    issue(4'd6, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
    check("madd_3x4", {HI, LO}, 64'd13);
`else
    check("madd_noop", {HI, LO}, 64'd1);
`endif

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 11));
      issue(op, pick(), pick());
    end

    // Reset in the middle of a divide discards it
    Start = 1'b1; MDOp = 4'd2; SrcA = 32'd1000; SrcB = 32'd7;
    tick;
    Start = 1'b0;
    tick;
    tick;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("reset_mid_busy", 64'(Busy), 64'd0);
    check("reset_mid_hilo", {HI, LO}, 64'd0);
    repeat (12) tick;
    check("reset_mid_hilo_later", {HI, LO}, 64'd0);

    issue(4'd1, 32'd6, 32'd7);
    check("post_reset_multu", {HI, LO}, 64'd42);

    repeat (3) tick;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
